// File: rtl/eaglesong_absorb_seq.sv
// rtl/eaglesong_absorb_seq.sv - multi-block Eaglesong sponge absorb engine
//
// Packs and pads rate-sized message chunks, XORs them into a 16-word state
// and drives an external permutation core over a start/done handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        chunk handshake
//   in_data                  chunk, byte k at bits [8k+7:8k]
//   in_len_bytes, in_last    valid byte count (final chunk only), final flag
//   perm_start               one-cycle permutation request
//   perm_state_out           state handed to the permutation core
//   perm_done, perm_state_in permutation result
//   out_valid/out_ready      absorbed-state handshake
//   state_out                absorbed state
//   busy                     engine not idle
`timescale 1ns/1ps
module eaglesong_absorb_seq #(
    parameter int          RATE_WORDS  = 8,
    parameter int          STATE_WORDS = 16,
    parameter logic [7:0]  DELIM       = 8'h06,
    parameter int          LEN_W       = $clog2(4*RATE_WORDS+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [RATE_WORDS*32-1:0]    in_data,
    input  logic [LEN_W-1:0]            in_len_bytes,
    input  logic                        in_last,
    output logic                        perm_start,
    output logic [STATE_WORDS*32-1:0]   perm_state_out,
    input  logic                        perm_done,
    input  logic [STATE_WORDS*32-1:0]   perm_state_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [STATE_WORDS*32-1:0]   state_out,
    output logic                        busy
);

    localparam int RATE_BYTES = 4*RATE_WORDS;
    localparam int SW         = STATE_WORDS*32;

    typedef enum logic [1:0] {IDLE, PERM_WAIT, PAD, DONE} fsm_t;

    fsm_t                   fsm_q, fsm_d;
    logic [SW-1:0]          state_q, state_d;
    logic                   pad_q, pad_d;
    logic                   last_q, last_d;
    logic                   start_q, start_d;

    logic [LEN_W-1:0]       len_sat;
    logic [7:0]             blk_b [RATE_BYTES];
    logic [RATE_BYTES*8-1:0] blk;

    // Block build: data bytes below the (saturated) length, delimiter at the
    // length position, zeros above it. A full-length final chunk carries no
    // delimiter here; it is absorbed later in the PAD block.
    always_comb begin
        len_sat = (in_len_bytes >= LEN_W'(RATE_BYTES)) ? LEN_W'(RATE_BYTES) : in_len_bytes;
        for (int k = 0; k < RATE_BYTES; k++) begin
            if (!in_last || (LEN_W'(k) < len_sat))
                blk_b[k] = in_data[8*k +: 8];
            else if (LEN_W'(k) == len_sat)
                blk_b[k] = DELIM;
            else
                blk_b[k] = 8'h00;
        end
        // Big-endian packing: lowest-numbered byte lands in the word MSB.
        for (int i = 0; i < RATE_WORDS; i++)
            blk[32*i +: 32] = {blk_b[4*i], blk_b[4*i+1], blk_b[4*i+2], blk_b[4*i+3]};
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        pad_d   = pad_q;
        last_d  = last_q;
        start_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < RATE_WORDS; i++)
                        state_d[32*i +: 32] = state_q[32*i +: 32] ^ blk[32*i +: 32];
                    start_d = 1'b1;
                    last_d  = in_last;
                    pad_d   = in_last && (in_len_bytes >= LEN_W'(RATE_BYTES));
                    fsm_d   = PERM_WAIT;
                end
            end
            PERM_WAIT: begin
                // A done coincident with our own start pulse belongs to no
                // permutation we issued, so it is ignored.
                if (perm_done && !start_q) begin
                    state_d = perm_state_in;
                    if (pad_q)
                        fsm_d = PAD;
                    else if (last_q)
                        fsm_d = DONE;
                    else
                        fsm_d = IDLE;
                end
            end
            PAD: begin
                state_d[31:0] = state_q[31:0] ^ {DELIM, 24'h000000};
                pad_d         = 1'b0;
                start_d       = 1'b1;
                fsm_d         = PERM_WAIT;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = '0;
                    last_d  = 1'b0;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            start_q <= start_d;
        end
    end

    assign in_ready       = (fsm_q == IDLE);
    assign busy           = (fsm_q != IDLE);
    assign out_valid      = (fsm_q == DONE);
    assign perm_start     = start_q;
    assign perm_state_out = state_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_eaglesong_absorb_seq.sv
// tb/tb_eaglesong_absorb_seq.sv - directed bench for eaglesong_absorb_seq
`timescale 1ns/1ps
module tb_eaglesong_absorb_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic [5:0]   in_len_bytes = '0;
    logic         in_last = 1'b0;
    logic         perm_start;
    logic [511:0] perm_state_out;
    logic         perm_done;
    logic [511:0] perm_state_in;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] state_out;
    logic         busy;

    logic         stub_done = 1'b0;
    logic         stray_done = 1'b0;
    int           stub_cnt = 0;
    int           starts = 0;

    int           nvec = 0;
    int           nerr = 0;
    int           s0;
    logic [255:0] d32;

    localparam logic [255:0] HELLO = 256'h0A21646C726F77202C6F6C6C6548;
    localparam logic [255:0] HELLO_JUNK = {{18{8'hA5}}, 112'h0A21646C726F77202C6F6C6C6548};
    logic [31:0] hello_exp [4] = '{32'h48656C6C, 32'h6F2C2077, 32'h6F726C64, 32'h210A0600};
    logic [31:0] full_exp  [8] = '{32'h06010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                                   32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};

    eaglesong_absorb_seq dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_len_bytes   (in_len_bytes),
        .in_last        (in_last),
        .perm_start     (perm_start),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done),
        .perm_state_in  (perm_state_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .state_out      (state_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Identity permutation stub, done three cycles after each start.
    assign perm_state_in = perm_state_out;
    assign perm_done     = stub_done | stray_done;

    always @(negedge clk) begin
        if (rst) begin
            stub_cnt  = 0;
            stub_done = 1'b0;
        end else begin
            stub_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) stub_done = 1'b1;
            end
            if (perm_start) begin
                stub_cnt = 3;
                starts++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w(input int i);
        return state_out[32*i +: 32];
    endfunction

    task automatic send(input logic [255:0] d, input logic [5:0] len, input logic last);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_len_bytes = len; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; in_len_bytes = '0; in_last = 1'b0;
        check("start_pulse", {31'b0, perm_start}, 32'd1);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("in_ready_low", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic wait_out();
        int t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ack_in_ready", {31'b0, in_ready}, 32'd1);
        check("ack_out_valid", {31'b0, out_valid}, 32'd0);
        check("ack_state_zero", w(0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_perm_start", {31'b0, perm_start}, 32'd0);
        check("rst_state", w(0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Hello, world
        s0 = starts;
        send(HELLO, 6'd14, 1'b1);
        wait_out();
        for (int i = 0; i < 4; i++) check("hello_word", w(i), hello_exp[i]);
        for (int i = 4; i < 16; i++) check("hello_zero", w(i), 32'd0);
        check("hello_starts", starts - s0, 32'd1);
        ack();

        // Full final chunk, length over-range saturates, pad block follows
        for (int k = 0; k < 32; k++) d32[8*k +: 8] = 8'(k);
        s0 = starts;
        send(d32, 6'd40, 1'b1);
        wait_out();
        for (int i = 0; i < 8; i++) check("full_word", w(i), full_exp[i]);
        check("full_cap", w(8), 32'd0);
        check("full_starts", starts - s0, 32'd2);
        ack();

        // Empty message, data bytes must be ignored
        s0 = starts;
        send({256{1'b1}}, 6'd0, 1'b1);
        wait_out();
        check("empty_word0", w(0), 32'h06000000);
        for (int i = 1; i < 16; i++) check("empty_zero", w(i), 32'd0);
        check("empty_starts", starts - s0, 32'd1);
        ack();

        // Two chunks, then hold off the consumer for 10 cycles
        s0 = starts;
        send({256{1'b1}}, 6'd3, 1'b0);
        send(256'h04030201, 6'd4, 1'b1);
        wait_out();
        check("two_word0", w(0), 32'hFEFDFCFB);
        check("two_word1", w(1), 32'hF9FFFFFF);
        for (int i = 2; i < 8; i++) check("two_rate", w(i), 32'hFFFFFFFF);
        for (int i = 8; i < 16; i++) check("two_cap", w(i), 32'd0);
        check("two_starts", starts - s0, 32'd2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_state", w(0), 32'hFEFDFCFB);
        end
        ack();

        // Reset while a permutation is outstanding
        send(HELLO_JUNK, 6'd14, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_perm_start", {31'b0, perm_start}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_state", w(0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("stray_busy", {31'b0, busy}, 32'd0);
        check("stray_in_ready", {31'b0, in_ready}, 32'd1);
        check("stray_state", w(0), 32'd0);
        s0 = starts;
        send(HELLO_JUNK, 6'd14, 1'b1);
        wait_out();
        for (int i = 0; i < 4; i++) check("rehello_word", w(i), hello_exp[i]);
        for (int i = 4; i < 16; i++) check("rehello_zero", w(i), 32'd0);
        check("rehello_starts", starts - s0, 32'd1);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
